rv_mem_arbiter2: RTL and testbench
==================================

// Module: rv_mem_arbiter2
// PURPOSE
//  Two-requester front end for one single-cycle rv_mem memory port (one side of rv_memory_double).
//  - Round-robin arbitrates two rv_mem command streams onto one registered memory command stream.
//  - Steers each memory result back to the requester that issued it, using an in-order tag FIFO.
// PARAMETERS
//  WRITE_PROPAGATE  0  1: memory returns a result for writes too; 0: reads only produce results
//  TAG_DEPTH        4  max commands awaiting a result (power of 2, >=2)
// PORTS
//  clk      in   1               clock
//  rst      in   1               synchronous, active-high reset
//  req0     in   rv_mem.in       requester 0 commands (valid/ready/op/addr/data)
//  resp0    out  rv_mem.out      requester 0 results
//  req1     in   rv_mem.in       requester 1 commands
//  resp1    out  rv_mem.out      requester 1 results
//  mem_cmd  out  rv_mem.out      commands to memory
//  mem_res  in   rv_mem.in       results from memory
//  err      out  1               sticky: result arrived with the tag FIFO empty
//  DATA_WIDTH and ADDR_WIDTH come from the interfaces; all six must match (STATIC_ASSERT).
// BEHAVIOUR
//  Reset: mem_cmd.valid=0, resp0/1.valid=0, tag FIFO empty, round-robin pointer=req0, err=0.
//  Command path: mem_cmd is a one-entry output register.
//   - The register can load when (!mem_cmd.valid || mem_cmd.ready) && !tag_full.
//   - Grant is taken when the register can load and a request is valid.
//   - Both requests valid: pointer side wins. Pointer then moves to the loser.
//   - One request valid: it wins. Pointer moves to the other requester.
//   - req.ready = grant to that requester (combinational). No request is lost or duplicated.
//   - Latency: a request accepted in cycle N appears on mem_cmd.valid in N+1.
//     op/addr/data are passed unchanged.
//   - mem_cmd payload holds while valid && !ready.
//  Tag FIFO: 1-bit requester ID, written on grant.
//   - Write condition: op==RV_MEM_READ || WRITE_PROPAGATE!=0.
//   - tag_full := count==TAG_DEPTH. When full, no grant, even if a pop happens the same cycle.
//   - Push and pop in the same cycle: count unchanged. Pointers wrap modulo TAG_DEPTH.
//  Result path (combinational steering, no added latency):
//   - respX.valid = mem_res.valid && !tag_empty && head==X.
//   - respX.op/addr/data = mem_res fields.
//   - mem_res.ready = !tag_empty && resp[head].ready. Pop on mem_res.valid && mem_res.ready.
//   - Backpressure on one response blocks the other (in-order); this is intended.
//  Error: mem_res.valid while tag_empty -> err<=1 the next cycle, held until rst.
//   - The stray result is not acknowledged (mem_res.ready=0).
//  Reset mid-transfer: in-flight command register and tags are discarded.
//   - The memory must be reset in the same cycle.
// STRUCTURE
//  Shared package rv_mem_pkg (existing): RV_MEM_READ/RV_MEM_WRITE op enum.
//   - Add typedef rv_mem_tag_t (1-bit requester ID).
//  Sub-module rv_mem_tag_fifo #(WIDTH, DEPTH): sync FIFO with push, pop, head, full, empty, count.
//   - Reusable by future N-way arbiters.
//  Arbiter and command register stay inline.
// TESTING
//  1 req0 reads addr 5, req1 idle, memory loaded with 0xA5 -> mem_cmd valid 1 cycle later;
//    resp0 data=0xA5, addr=5; resp1 never valid.
//  2 Both request reads every cycle for 8 cycles -> grants alternate 0,1,0,1...;
//    each resp gets its own 4 results in order.
//  3 WRITE_PROPAGATE=0: req1 writes 0x3C@2, then req0 reads @2 -> no result for the write;
//    resp0 data=0x3C; FIFO count peaks at 1.
//  4 resp0.ready=0 with 4 reads outstanding, TAG_DEPTH=4 -> req0/req1.ready=0 until a pop;
//    mem_cmd payload stable while mem_cmd.ready=0.
//  5 Inject mem_res.valid with the FIFO empty -> err=1 next cycle and held; mem_res.ready=0;
//    rst clears err.
//  6 Assert rst with 2 reads in flight -> the next cycle all valids are 0 and the FIFO is empty;
//    a fresh read completes normally.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared rv_mem definitions: command opcodes and the requester tag carried by the
// arbiters' tag FIFOs.
package rv_mem_pkg;

  typedef enum logic {
    RV_MEM_READ  = 1'b0,
    RV_MEM_WRITE = 1'b1
  } rv_mem_op_t;

  // Requester ID stored per outstanding command of a two-way arbiter.
  typedef logic rv_mem_tag_t;

  localparam rv_mem_tag_t TAG_REQ0 = 1'b0;
  localparam rv_mem_tag_t TAG_REQ1 = 1'b1;

  function automatic rv_mem_tag_t other_tag(rv_mem_tag_t tag);
    return ~tag;
  endfunction

endpackage

// File: rtl/rv_mem_tag_fifo.sv
// Synchronous FIFO of requester tags; DEPTH must be a power of two so the pointers
// wrap by natural overflow.
module rv_mem_tag_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH + 1)-1:0]   count
);

  localparam int unsigned PtrWidth = $clog2(DEPTH);
  localparam int unsigned CntWidth = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    storage_q [DEPTH];
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [CntWidth-1:0] count_q;
  logic                do_push;
  logic                do_pop;

  always_comb begin
    full    = (count_q == CntWidth'(DEPTH));
    empty   = (count_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = storage_q[rd_ptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntWidth'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntWidth'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (do_push) begin
      storage_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/rv_mem_arbiter2.sv
// Two-requester front end for one single-cycle rv_mem port: round-robin command merge into
// a one-entry output register, results steered back in order via a requester-tag FIFO.
module rv_mem_arbiter2
  import rv_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned WRITE_PROPAGATE = 0,
  parameter int unsigned TAG_DEPTH       = 4
) (
  input  logic                               clk,
  input  logic                               rst,

  input  logic                               req0_valid,
  output logic                               req0_ready,
  input  logic                               req0_op,
  input  logic [ADDR_WIDTH-1:0]              req0_addr,
  input  logic [DATA_WIDTH-1:0]              req0_data,

  output logic                               resp0_valid,
  input  logic                               resp0_ready,
  output logic                               resp0_op,
  output logic [ADDR_WIDTH-1:0]              resp0_addr,
  output logic [DATA_WIDTH-1:0]              resp0_data,

  input  logic                               req1_valid,
  output logic                               req1_ready,
  input  logic                               req1_op,
  input  logic [ADDR_WIDTH-1:0]              req1_addr,
  input  logic [DATA_WIDTH-1:0]              req1_data,

  output logic                               resp1_valid,
  input  logic                               resp1_ready,
  output logic                               resp1_op,
  output logic [ADDR_WIDTH-1:0]              resp1_addr,
  output logic [DATA_WIDTH-1:0]              resp1_data,

  output logic                               mem_cmd_valid,
  input  logic                               mem_cmd_ready,
  output logic                               mem_cmd_op,
  output logic [ADDR_WIDTH-1:0]              mem_cmd_addr,
  output logic [DATA_WIDTH-1:0]              mem_cmd_data,

  input  logic                               mem_res_valid,
  output logic                               mem_res_ready,
  input  logic                               mem_res_op,
  input  logic [ADDR_WIDTH-1:0]              mem_res_addr,
  input  logic [DATA_WIDTH-1:0]              mem_res_data,

  output logic                               err,
  output logic [$clog2(TAG_DEPTH + 1)-1:0]   tag_count
);

  // Command register and arbitration state.
  logic                  cmd_valid_q;
  logic                  cmd_op_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic [DATA_WIDTH-1:0] cmd_data_q;
  rv_mem_tag_t           rr_ptr_q;
  logic                  err_q;

  logic                  can_load;
  logic                  grant0;
  logic                  grant1;
  logic                  grant_any;
  logic                  win_op;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  // Tag FIFO interface.
  logic                  tag_push;
  logic                  tag_pop;
  rv_mem_tag_t           tag_in;
  rv_mem_tag_t           tag_head;
  logic                  tag_full;
  logic                  tag_empty;

  always_comb begin
    // A pop in the same cycle does not free a slot for this cycle's grant.
    can_load  = (!cmd_valid_q || mem_cmd_ready) && !tag_full;
    grant0    = can_load && req0_valid && (!req1_valid || rr_ptr_q == TAG_REQ0);
    grant1    = can_load && req1_valid && (!req0_valid || rr_ptr_q == TAG_REQ1);
    grant_any = grant0 || grant1;

    win_op    = grant1 ? req1_op   : req0_op;
    win_addr  = grant1 ? req1_addr : req0_addr;
    win_data  = grant1 ? req1_data : req0_data;

    tag_in    = grant1 ? TAG_REQ1 : TAG_REQ0;
    tag_push  = grant_any && (win_op == RV_MEM_READ || WRITE_PROPAGATE != 0);

    req0_ready = grant0;
    req1_ready = grant1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      rr_ptr_q    <= TAG_REQ0;
      err_q       <= 1'b0;
    end else begin
      if (!cmd_valid_q || mem_cmd_ready) begin
        cmd_valid_q <= grant_any;
      end
      if (grant_any) begin
        rr_ptr_q <= other_tag(tag_in);
      end
      if (mem_res_valid && tag_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  // Payload only moves on a grant, so it holds while the memory stalls.
  always_ff @(posedge clk) begin
    if (grant_any) begin
      cmd_op_q   <= win_op;
      cmd_addr_q <= win_addr;
      cmd_data_q <= win_data;
    end
  end

  rv_mem_tag_fifo #(
    .WIDTH (1),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (tag_in),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  always_comb begin
    resp0_valid = mem_res_valid && !tag_empty && (tag_head == TAG_REQ0);
    resp1_valid = mem_res_valid && !tag_empty && (tag_head == TAG_REQ1);
    resp0_op    = mem_res_op;
    resp0_addr  = mem_res_addr;
    resp0_data  = mem_res_data;
    resp1_op    = mem_res_op;
    resp1_addr  = mem_res_addr;
    resp1_data  = mem_res_data;

    // Stray results (no tag outstanding) are never acknowledged.
    mem_res_ready = !tag_empty && ((tag_head == TAG_REQ1) ? resp1_ready : resp0_ready);
    tag_pop       = mem_res_valid && mem_res_ready;

    mem_cmd_valid = cmd_valid_q;
    mem_cmd_op    = cmd_op_q;
    mem_cmd_addr  = cmd_addr_q;
    mem_cmd_data  = cmd_data_q;
    err           = err_q;
  end

endmodule

// File: tb/tb_rv_mem_arbiter2.sv
// Randomized bench for rv_mem_arbiter2 with a behavioural memory and a queue-based
// reference model of arbitration order and result routing.
module tb_rv_mem_arbiter2;
  import rv_mem_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 4;

  typedef logic [16:0] res_t;  // {op, addr, data}

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req0_op;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic resp0_valid, resp0_ready, resp0_op;
  logic [AW-1:0] resp0_addr;
  logic [DW-1:0] resp0_data;
  logic req1_valid, req1_ready, req1_op;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic resp1_valid, resp1_ready, resp1_op;
  logic [AW-1:0] resp1_addr;
  logic [DW-1:0] resp1_data;
  logic mem_cmd_valid, mem_cmd_ready, mem_cmd_op;
  logic [AW-1:0] mem_cmd_addr;
  logic [DW-1:0] mem_cmd_data;
  logic mem_res_valid, mem_res_ready, mem_res_op;
  logic [AW-1:0] mem_res_addr;
  logic [DW-1:0] mem_res_data;
  logic err;
  logic [2:0] tag_count;

  rv_mem_arbiter2 #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .WRITE_PROPAGATE (0),
    .TAG_DEPTH       (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_op       (req0_op),
    .req0_addr     (req0_addr),
    .req0_data     (req0_data),
    .resp0_valid   (resp0_valid),
    .resp0_ready   (resp0_ready),
    .resp0_op      (resp0_op),
    .resp0_addr    (resp0_addr),
    .resp0_data    (resp0_data),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_op       (req1_op),
    .req1_addr     (req1_addr),
    .req1_data     (req1_data),
    .resp1_valid   (resp1_valid),
    .resp1_ready   (resp1_ready),
    .resp1_op      (resp1_op),
    .resp1_addr    (resp1_addr),
    .resp1_data    (resp1_data),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_cmd_op    (mem_cmd_op),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_cmd_data  (mem_cmd_data),
    .mem_res_valid (mem_res_valid),
    .mem_res_ready (mem_res_ready),
    .mem_res_op    (mem_res_op),
    .mem_res_addr  (mem_res_addr),
    .mem_res_data  (mem_res_data),
    .err           (err),
    .tag_count     (tag_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state: memory contents as seen in grant order, per-requester expected
  // results, and the global order in which results must come back.
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] sim_mem [256];
  res_t exp_q0[$];
  res_t exp_q1[$];
  res_t mres_q[$];
  bit   ord_q[$];
  bit   last_win;
  bit   exp_cmd_valid;
  res_t exp_cmd;
  bit   exp_err;
  bit   acc0, acc1, res_acc, drove_stray, stray;
  int   p_req0, p_req1, p_wr, p_mrdy, p_mres, p_r0, p_r1;
  int   peak;

  function automatic bit rnd(input int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic drive();
    if (!req0_valid || acc0) begin
      req0_valid = rnd(p_req0);
      req0_op    = rnd(p_wr);
      req0_addr  = AW'($urandom_range(7));
      req0_data  = DW'($urandom);
    end
    if (!req1_valid || acc1) begin
      req1_valid = rnd(p_req1);
      req1_op    = rnd(p_wr);
      req1_addr  = AW'($urandom_range(7));
      req1_data  = DW'($urandom);
    end
    drove_stray = 1'b0;
    if (mres_q.size() > 0) begin
      if (!(mem_res_valid && !res_acc)) mem_res_valid = rnd(p_mres);
      {mem_res_op, mem_res_addr, mem_res_data} = mres_q[0];
    end else if (stray) begin
      mem_res_valid = 1'b1;
      {mem_res_op, mem_res_addr, mem_res_data} = 17'($urandom);
      drove_stray = 1'b1;
    end else begin
      mem_res_valid = 1'b0;
    end
    mem_cmd_ready = rnd(p_mrdy);
    resp0_ready   = rnd(p_r0);
    resp1_ready   = rnd(p_r1);
  endtask

  task automatic step();
    bit   v0, v1, can, g0, g1, h;
    res_t cmd;
    @(negedge clk);
    v0  = req0_valid;
    v1  = req1_valid;
    can = (!exp_cmd_valid || mem_cmd_ready) && (ord_q.size() < DEPTH);
    g0  = can && v0 && (!v1 || last_win);
    g1  = can && v1 && (!v0 || !last_win);
    check("req0_ready", 32'(req0_ready), 32'(g0));
    check("req1_ready", 32'(req1_ready), 32'(g1));
    acc0    = v0 && req0_ready;
    acc1    = v1 && req1_ready;
    res_acc = mem_res_valid && mem_res_ready;

    // Behavioural memory.
    if (res_acc && !drove_stray && mres_q.size() > 0) void'(mres_q.pop_front());
    if (mem_cmd_valid && mem_cmd_ready) begin
      if (mem_cmd_op == RV_MEM_READ)
        mres_q.push_back({mem_cmd_op, mem_cmd_addr, sim_mem[mem_cmd_addr]});
      else
        sim_mem[mem_cmd_addr] = mem_cmd_data;
    end

    // Result routing against the oldest outstanding read.
    if (ord_q.size() == 0) begin
      check("mem_res_ready_idle", 32'(mem_res_ready), 32'(0));
      check("resp_valid_idle", 32'({resp0_valid, resp1_valid}), 32'(0));
      if (mem_res_valid) exp_err = 1'b1;
    end else begin
      h = ord_q[0];
      check("mem_res_ready", 32'(mem_res_ready), 32'(h ? resp1_ready : resp0_ready));
      if (!mem_res_valid) begin
        check("resp_valid_none", 32'({resp0_valid, resp1_valid}), 32'(0));
      end else if (!h) begin
        check("resp0_valid", 32'({resp0_valid, resp1_valid}), 32'(2'b10));
        check("resp0_payload", 32'({resp0_op, resp0_addr, resp0_data}), 32'(exp_q0[0]));
        if (resp0_ready) begin
          void'(exp_q0.pop_front());
          void'(ord_q.pop_front());
        end
      end else begin
        check("resp1_valid", 32'({resp0_valid, resp1_valid}), 32'(2'b01));
        check("resp1_payload", 32'({resp1_op, resp1_addr, resp1_data}), 32'(exp_q1[0]));
        if (resp1_ready) begin
          void'(exp_q1.pop_front());
          void'(ord_q.pop_front());
        end
      end
    end

    cmd = g1 ? {req1_op, req1_addr, req1_data} : {req0_op, req0_addr, req0_data};
    if (g0 || g1) begin
      last_win = g1;
      if (cmd[16] == RV_MEM_READ) begin
        ord_q.push_back(g1);
        if (g1) exp_q1.push_back({cmd[16:8], ref_mem[cmd[15:8]]});
        else    exp_q0.push_back({cmd[16:8], ref_mem[cmd[15:8]]});
      end else begin
        ref_mem[cmd[15:8]] = cmd[7:0];
      end
    end
    if (!exp_cmd_valid || mem_cmd_ready) begin
      exp_cmd_valid = g0 || g1;
      if (g0 || g1) exp_cmd = cmd;
    end

    @(posedge clk);
    #1;
    check("mem_cmd_valid", 32'(mem_cmd_valid), 32'(exp_cmd_valid));
    if (exp_cmd_valid)
      check("mem_cmd_payload", 32'({mem_cmd_op, mem_cmd_addr, mem_cmd_data}), 32'(exp_cmd));
    check("err", 32'(err), 32'(exp_err));
    check("tag_count", 32'(tag_count), 32'(ord_q.size()));
    if (int'(tag_count) > peak) peak = int'(tag_count);
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    mem_res_valid = 1'b0;
    mem_cmd_ready = 1'b0;
    stray = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ord_q.delete();
    exp_q0.delete();
    exp_q1.delete();
    mres_q.delete();
    exp_cmd_valid = 1'b0;
    exp_err  = 1'b0;
    last_win = 1'b1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    res_acc = 1'b0;
    check("rst_mem_cmd_valid", 32'(mem_cmd_valid), 32'(0));
    check("rst_resp_valid", 32'({resp0_valid, resp1_valid}), 32'(0));
    check("rst_tag_count", 32'(tag_count), 32'(0));
    check("rst_err", 32'(err), 32'(0));
  endtask

  task automatic set_idle();
    p_req0 = 0; p_req1 = 0; p_wr = 0;
    p_mrdy = 100; p_mres = 100; p_r0 = 100; p_r1 = 100;
  endtask

  task automatic drain();
    set_idle();
    for (int i = 0; i < 300; i++) begin
      if (ord_q.size() == 0 && !exp_cmd_valid && mres_q.size() == 0 &&
          !req0_valid && !req1_valid) return;
      step();
    end
    check("drain_timeout", 32'(ord_q.size()), 32'(0));
  endtask

  task automatic issue(input bit side, input logic op, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data);
    if (!side) {req0_valid, req0_op, req0_addr, req0_data} = {1'b1, op, addr, data};
    else       {req1_valid, req1_op, req1_addr, req1_data} = {1'b1, op, addr, data};
    for (int i = 0; i < 50; i++) begin
      step();
      if (side ? acc1 : acc0) return;
    end
    check("issue_timeout", 32'(side ? req1_valid : req0_valid), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int cnt0, cnt1;
    rst = 1'b1;
    {req0_valid, req0_op, req0_addr, req0_data} = '0;
    {req1_valid, req1_op, req1_addr, req1_data} = '0;
    {mem_res_valid, mem_res_op, mem_res_addr, mem_res_data} = '0;
    {mem_cmd_ready, resp0_ready, resp1_ready} = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = DW'($urandom);
      sim_mem[i] = ref_mem[i];
    end
    set_idle();
    stray = 1'b0;
    peak = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Single read from requester 0.
    ref_mem[5] = 8'hA5;
    sim_mem[5] = 8'hA5;
    issue(1'b0, RV_MEM_READ, 8'd5, 8'h00);
    drain();

    // Both requesters reading every cycle.
    p_req0 = 100; p_req1 = 100;
    step();
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      cnt0 += int'(acc0);
      cnt1 += int'(acc1);
    end
    check("alt_grants0", 32'(cnt0), 32'(4));
    check("alt_grants1", 32'(cnt1), 32'(4));
    drain();

    // Write gives no result; the following read sees the written data.
    peak = 0;
    issue(1'b1, RV_MEM_WRITE, 8'd2, 8'h3C);
    issue(1'b0, RV_MEM_READ, 8'd2, 8'h00);
    drain();
    check("wr_peak_count", 32'(peak), 32'(1));

    // Tag FIFO fills while resp0 stalls.
    p_req0 = 100; p_r0 = 0; p_mrdy = 50;
    repeat (30) step();
    check("full_tag_count", 32'(tag_count), 32'(DEPTH));
    check("full_req0_blocked", 32'(req0_ready), 32'(0));
    drain();

    // Stray result with nothing outstanding.
    stray = 1'b1;
    step();
    stray = 1'b0;
    repeat (4) step();
    check("err_sticky", 32'(err), 32'(1));
    do_reset();

    // Reset with reads in flight, then a fresh read.
    p_req0 = 100; p_req1 = 100; p_r0 = 0; p_r1 = 0;
    for (int i = 0; i < 20; i++) begin
      if (ord_q.size() >= 2) break;
      step();
    end
    check("inflight_before_rst", 32'(tag_count >= 3'd2), 32'(1));
    do_reset();
    set_idle();
    issue(1'b1, RV_MEM_READ, 8'd3, 8'h00);
    drain();

    // Randomized traffic.
    for (int seg = 0; seg < 6; seg++) begin
      p_req0 = $urandom_range(90, 20);
      p_req1 = $urandom_range(90, 20);
      p_wr   = 30;
      p_mrdy = $urandom_range(100, 30);
      p_mres = $urandom_range(100, 30);
      p_r0   = $urandom_range(100, 30);
      p_r1   = $urandom_range(100, 30);
      repeat (300) step();
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
